// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
// Shared definitions for the pipelined logic unit:
//   - opcode encodings carried on ALU_FUN[2:0]
//   - index of the illegal-opcode bit within ALU_FUN
//   - layout of the per-stage payload: {err, par, zero, result[WIDTH-1:0]}
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    // Opcodes on ALU_FUN[2:0]
    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NAND  = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOTA  = 3'd6;
    localparam logic [2:0] OP_PASSA = 3'd7;

    // ALU_FUN[3] set marks the transaction as illegal
    localparam int ERR_BIT = 3;

    // Payload = result followed by three flag bits, placed just above it
    localparam int FLAG_W   = 3;
    localparam int FLD_ZERO = 0;
    localparam int FLD_PAR  = 1;
    localparam int FLD_ERR  = 2;

    function automatic int payload_width(input int width);
        return width + FLAG_W;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_stage.sv
// -----------------------------------------------------------------------------
// logic_pipe_stage
// One elastic register stage of the logic unit pipeline. Holds a valid bit
// and a payload; loads whenever it is empty or its contents are leaving.
// Ports:
//   clk, RST       clock, synchronous active-high reset
//   i_vld, i_data  upstream valid / payload
//   i_rdy          downstream can take this stage's contents this cycle
//   o_vld, o_data  registered valid / payload
// The upstream-facing ready is computed by the parent from all stage valids,
// so the ready chain has no combinational path through these instances.
// -----------------------------------------------------------------------------
module logic_pipe_stage
    import logic_unit_pkg::*;
#(
    parameter int PL_W = payload_width(16)
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            i_vld,
    input  logic [PL_W-1:0] i_data,
    input  logic            i_rdy,
    output logic            o_vld,
    output logic [PL_W-1:0] o_data
);

    logic            r_vld;
    logic [PL_W-1:0] r_data;
    logic            w_load;

    // Stage may take new contents when empty or when its contents move on
    assign w_load = !r_vld || i_rdy;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_vld  <= 1'b0;
            r_data <= '0;
        end else if (w_load) begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_data <= i_data;
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;

endmodule

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
// Elastic, pipelined bitwise logic unit. Computes one of eight bitwise
// functions of A and B, derives zero/parity/illegal flags, and carries the
// result through PIPE_DEPTH valid/ready register stages with backpressure.
// Ports:
//   clk, RST    clock, synchronous active-high reset
//   A, B        WIDTH-bit operands
//   ALU_FUN     [2:0] opcode, [3] illegal marker
//   Logic_EN    input valid;  Logic_RDY  unit can accept this cycle
//   Out_RDY     downstream ready
//   Logic_OUT   result (0 when Logic_Flag=0)
//   Logic_Flag  result valid
//   Logic_Zero  result is zero;  Logic_Par  XOR of result bits
//   Logic_Err   transaction carried ALU_FUN[3]=1
//   Ops_CNT     completed output transfers, wrapping
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    input  logic             Logic_EN,
    output logic             Logic_RDY,
    input  logic             Out_RDY,
    output logic [WIDTH-1:0] Logic_OUT,
    output logic             Logic_Flag,
    output logic             Logic_Zero,
    output logic             Logic_Par,
    output logic             Logic_Err,
    output logic [CNT_W-1:0] Ops_CNT
);

    localparam int PL_W = payload_width(WIDTH);

    // ---------------------------------------------------------------------
    // Input-side function and flag generation
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] w_res;
    logic             w_err;
    logic             w_zero;
    logic             w_par;

    always_comb begin
        w_res = '0;
        w_err = ALU_FUN[ERR_BIT];
        // Illegal opcodes keep the forced-zero result
        if (!w_err) begin
            case (ALU_FUN[2:0])
                OP_AND:   w_res = A & B;
                OP_OR:    w_res = A | B;
                OP_NAND:  w_res = ~(A & B);
                OP_NOR:   w_res = ~(A | B);
                OP_XOR:   w_res = A ^ B;
                OP_XNOR:  w_res = ~(A ^ B);
                OP_NOTA:  w_res = ~A;
                OP_PASSA: w_res = A;
                default:  w_res = '0;
            endcase
        end
        w_zero = ~|w_res;
        w_par  = ^w_res;
    end

    // ---------------------------------------------------------------------
    // Stage chain. Index k of w_vld/w_pl is the input of stage k; index
    // PIPE_DEPTH is the output of the last stage. w_rdy[k] means stage k
    // can load this cycle; w_rdy[PIPE_DEPTH] is the downstream ready.
    // ---------------------------------------------------------------------
    logic [PIPE_DEPTH:0]           w_vld;
    logic [PIPE_DEPTH:0][PL_W-1:0] w_pl;
    logic [PIPE_DEPTH:0]           w_rdy;

    assign w_vld[0] = Logic_EN && !RST;
    assign w_pl[0]  = {w_err, w_par, w_zero, w_res};

    assign w_rdy[PIPE_DEPTH] = Out_RDY;

    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_stage
        // Stage g can load when the output is taking data or any stage from
        // g onward holds a bubble; written from the stage valids directly
        // so ready never loops back through itself.
        assign w_rdy[g] = Out_RDY || !(&w_vld[PIPE_DEPTH:g+1]);

        logic_pipe_stage #(.PL_W(PL_W)) u_stage (
            .clk    (clk),
            .RST    (RST),
            .i_vld  (w_vld[g]),
            .i_data (w_pl[g]),
            .i_rdy  (w_rdy[g+1]),
            .o_vld  (w_vld[g+1]),
            .o_data (w_pl[g+1])
        );
    end

    // Nothing is accepted while reset is held
    assign Logic_RDY = !RST && w_rdy[0];

    // ---------------------------------------------------------------------
    // Output gating
    // ---------------------------------------------------------------------
    logic [PL_W-1:0] w_out_pl;

    assign Logic_Flag = w_vld[PIPE_DEPTH];
    assign w_out_pl   = Logic_Flag ? w_pl[PIPE_DEPTH] : '0;
    assign Logic_OUT  = w_out_pl[WIDTH-1:0];
    assign Logic_Zero = w_out_pl[WIDTH+FLD_ZERO];
    assign Logic_Par  = w_out_pl[WIDTH+FLD_PAR];
    assign Logic_Err  = w_out_pl[WIDTH+FLD_ERR];

    // ---------------------------------------------------------------------
    // Completed-transfer counter, wraps silently
    // ---------------------------------------------------------------------
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (Logic_Flag && Out_RDY) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign Ops_CNT = r_cnt;

endmodule
